// File: rtl/esc_spin_ctrl.sv
// Arm/spin-up sequencer for a four-motor ESC bank: zero-speed arming hold,
// slew-limited speed tracking, controlled ramp-down on disarm, immediate kill.
module esc_spin_ctrl #(
    parameter int unsigned ARM_CYCLES = 25_000_000,
    parameter int unsigned RAMP_DIV   = 50_000,
    parameter logic [10:0] RAMP_STEP  = 11'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        disarm,
    input  logic        kill,
    input  logic [10:0] frnt_tgt,
    input  logic [10:0] bck_tgt,
    input  logic [10:0] lft_tgt,
    input  logic [10:0] rght_tgt,
    output logic [10:0] frnt_spd,
    output logic [10:0] bck_spd,
    output logic [10:0] lft_spd,
    output logic [10:0] rght_spd,
    output logic        motors_off,
    output logic        armed,
    output logic        busy
);

    localparam int unsigned ARM_W  = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam int unsigned TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ARMING = 2'd1,
        RUN    = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ARM_W-1:0]  arm_cnt;
    logic [ARM_W-1:0]  arm_cnt_next;
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_cnt_next;
    logic [3:0][10:0]  spd;
    logic [3:0][10:0]  spd_next;
    logic [3:0][10:0]  tgt;
    logic              ramping;
    logic              ramping_next;
    logic              tick;
    logic              all_zero;

    assign tgt      = {rght_tgt, lft_tgt, bck_tgt, frnt_tgt};
    assign frnt_spd = spd[0];
    assign bck_spd  = spd[1];
    assign lft_spd  = spd[2];
    assign rght_spd = spd[3];

    assign ramping      = (state == RUN) || (state == STOP);
    assign ramping_next = (state_next == RUN) || (state_next == STOP);
    assign tick         = ramping && (tick_cnt == TICK_LAST);
    assign all_zero     = (spd == '0);

    // One slew step; the 12-bit difference keeps the clamp exact near 0 and 2047.
    function automatic logic [10:0] slew(input logic [10:0] cur, input logic [10:0] goal);
        logic [11:0] diff;
        logic [10:0] result;
        result = cur;
        diff   = '0;
        if (cur < goal) begin
            diff = {1'b0, goal} - {1'b0, cur};
            if (diff > {1'b0, RAMP_STEP}) begin
                result = cur + RAMP_STEP;
            end else begin
                result = goal;
            end
        end else if (cur > goal) begin
            diff = {1'b0, cur} - {1'b0, goal};
            if (diff > {1'b0, RAMP_STEP}) begin
                result = cur - RAMP_STEP;
            end else begin
                result = goal;
            end
        end
        return result;
    endfunction

    always_comb begin
        state_next   = state;
        arm_cnt_next = '0;
        spd_next     = spd;
        case (state)
            OFF: begin
                spd_next = '0;
                if (arm) begin
                    state_next = ARMING;
                end
            end
            ARMING: begin
                spd_next = '0;
                if (disarm) begin
                    state_next = OFF;
                end else if (arm_cnt == ARM_LAST) begin
                    state_next = RUN;
                end else begin
                    arm_cnt_next = arm_cnt + 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    for (int i = 0; i < 4; i++) begin
                        spd_next[i] = slew(spd[i], tgt[i]);
                    end
                end
                if (disarm) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (all_zero) begin
                    state_next = OFF;
                end else if (tick) begin
                    for (int i = 0; i < 4; i++) begin
                        spd_next[i] = slew(spd[i], 11'd0);
                    end
                end
            end
            default: begin
                state_next = OFF;
                spd_next   = '0;
            end
        endcase
        // Kill overrides every other request, including a same-edge disarm or tick.
        if (kill) begin
            state_next   = OFF;
            spd_next     = '0;
            arm_cnt_next = '0;
        end
    end

    // The tick phase carries across RUN->STOP so the ramp-down keeps its cadence.
    always_comb begin
        tick_cnt_next = '0;
        if (ramping && ramping_next) begin
            tick_cnt_next = tick ? '0 : tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= OFF;
            arm_cnt    <= '0;
            tick_cnt   <= '0;
            spd        <= '0;
            motors_off <= 1'b1;
            armed      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            arm_cnt    <= arm_cnt_next;
            tick_cnt   <= tick_cnt_next;
            spd        <= spd_next;
            motors_off <= (state_next == OFF);
            armed      <= (state_next == RUN);
            busy       <= (state_next == ARMING) || (state_next == STOP);
        end
    end

endmodule

// File: tb/tb_esc_spin_ctrl.sv
// Scoreboard bench for esc_spin_ctrl: each entry carries the control inputs to
// drive, the cycles to advance, and the outputs expected afterwards.
module tb_esc_spin_ctrl;

    localparam int unsigned ARM_CYCLES = 10;
    localparam int unsigned RAMP_DIV   = 4;
    localparam logic [10:0] RAMP_STEP  = 11'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arm = 1'b0;
    logic        disarm = 1'b0;
    logic        kill = 1'b0;
    logic [10:0] frnt_tgt = '0;
    logic [10:0] bck_tgt = '0;
    logic [10:0] lft_tgt = '0;
    logic [10:0] rght_tgt = '0;
    logic [10:0] frnt_spd;
    logic [10:0] bck_spd;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        motors_off;
    logic        armed;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          gap;
        logic        a;
        logic        d;
        logic        k;
        string       name;
        logic [46:0] v;
    } ent_t;

    ent_t sb[$];

    esc_spin_ctrl #(
        .ARM_CYCLES(ARM_CYCLES),
        .RAMP_DIV  (RAMP_DIV),
        .RAMP_STEP (RAMP_STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .disarm    (disarm),
        .kill      (kill),
        .frnt_tgt  (frnt_tgt),
        .bck_tgt   (bck_tgt),
        .lft_tgt   (lft_tgt),
        .rght_tgt  (rght_tgt),
        .frnt_spd  (frnt_spd),
        .bck_spd   (bck_spd),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .motors_off(motors_off),
        .armed     (armed),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [46:0] ev(input int f, input int b, input int l, input int r,
                                       input logic mo, input logic ar, input logic bu);
        return {11'(f), 11'(b), 11'(l), 11'(r), mo, ar, bu};
    endfunction

    function automatic logic [46:0] obs();
        return {frnt_spd, bck_spd, lft_spd, rght_spd, motors_off, armed, busy};
    endfunction

    function automatic string fmt(input logic [46:0] v);
        return $sformatf("f=%0d b=%0d l=%0d r=%0d off=%0b armed=%0b busy=%0b",
                         v[46:36], v[35:25], v[24:14], v[13:3], v[2], v[1], v[0]);
    endfunction

    function automatic ent_t ent(input int gap, input logic a, input logic d, input logic k,
                                 input string name, input logic [46:0] v);
        ent_t e;
        e.gap  = gap;
        e.a    = a;
        e.d    = d;
        e.k    = k;
        e.name = name;
        e.v    = v;
        return e;
    endfunction

    function automatic int min_int(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== ev(0, 0, 0, 0, 1, 0, 0)) begin
            n_bad++;
            $display("[TB] FAIL reset_async: got %s, expected %s", fmt(obs()), fmt(ev(0, 0, 0, 0, 1, 0, 0)));
        end
        cyc(3);
        rst = 1'b0;
        cyc(1);
        n_cmp++;
        if (obs() !== ev(0, 0, 0, 0, 1, 0, 0)) begin
            n_bad++;
            $display("[TB] FAIL reset_release: got %s, expected %s", fmt(obs()), fmt(ev(0, 0, 0, 0, 1, 0, 0)));
        end
    endtask

    task automatic test_arm();
        ent_t e;
        frnt_tgt = 11'd20;
        sb.push_back(ent(1, 1, 0, 0, "arm_edge", ev(0, 0, 0, 0, 0, 0, 1)));
        for (int i = 1; i < 10; i++) begin
            sb.push_back(ent(1, 0, 0, 0, "arming_hold", ev(0, 0, 0, 0, 0, 0, 1)));
        end
        sb.push_back(ent(1, 0, 0, 0, "armed", ev(0, 0, 0, 0, 0, 1, 0)));
        sb.push_back(ent(1, 1, 0, 0, "arm_in_run", ev(0, 0, 0, 0, 0, 1, 0)));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            arm = e.a; disarm = e.d; kill = e.k;
            cyc(e.gap);
            n_cmp++;
            if (obs() !== e.v) begin
                n_bad++;
                $display("[TB] FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v));
            end
        end
        arm = 1'b0;
    endtask

    task automatic test_ramp_up();
        ent_t e;
        for (int k = 2; k <= 16; k++) begin
            sb.push_back(ent(1, 0, 0, 0, "ramp_up", ev(min_int(8 * (k / 4), 20), 0, 0, 0, 0, 1, 0)));
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            arm = e.a; disarm = e.d; kill = e.k;
            cyc(e.gap);
            n_cmp++;
            if (obs() !== e.v) begin
                n_bad++;
                $display("[TB] FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v));
            end
        end
    endtask

    task automatic test_retarget();
        ent_t e;
        frnt_tgt = 11'd5;
        sb.push_back(ent(3, 0, 0, 0, "retgt_hold", ev(20, 0, 0, 0, 0, 1, 0)));
        sb.push_back(ent(1, 0, 0, 0, "retgt_12", ev(12, 0, 0, 0, 0, 1, 0)));
        sb.push_back(ent(4, 0, 0, 0, "retgt_5", ev(5, 0, 0, 0, 0, 1, 0)));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            arm = e.a; disarm = e.d; kill = e.k;
            cyc(e.gap);
            n_cmp++;
            if (obs() !== e.v) begin
                n_bad++;
                $display("[TB] FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v));
            end
        end
        rght_tgt = 11'd2047;
        for (int t = 1; t <= 257; t++) begin
            sb.push_back(ent(4, 0, 0, 0, "rght_to_max", ev(5, 0, 0, min_int(8 * t, 2047), 0, 1, 0)));
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            arm = e.a; disarm = e.d; kill = e.k;
            cyc(e.gap);
            n_cmp++;
            if (obs() !== e.v) begin
                n_bad++;
                $display("[TB] FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v));
            end
        end
    endtask

    task automatic test_disarm();
        ent_t e;
        int   w;
        int   v;
        frnt_tgt = 11'd100; bck_tgt = 11'd100; lft_tgt = 11'd100; rght_tgt = 11'd100;
        w = 0;
        while (!(frnt_spd == 100 && bck_spd == 100 && lft_spd == 100 && rght_spd == 100) && w < 2000) begin
            cyc(1);
            w++;
        end
        n_cmp++;
        if (obs() !== ev(100, 100, 100, 100, 0, 1, 0)) begin
            n_bad++;
            $display("[TB] FAIL reach_100: got %s, expected %s", fmt(obs()), fmt(ev(100, 100, 100, 100, 0, 1, 0)));
        end
        sb.push_back(ent(1, 0, 1, 0, "disarm_edge", ev(100, 100, 100, 100, 0, 0, 1)));
        sb.push_back(ent(3, 0, 0, 0, "stop_tick1", ev(92, 92, 92, 92, 0, 0, 1)));
        for (int i = 2; i <= 13; i++) begin
            v = (100 - 8 * i < 0) ? 0 : 100 - 8 * i;
            sb.push_back(ent(4, 0, 0, 0, "stop_ramp", ev(v, v, v, v, 0, 0, 1)));
        end
        sb.push_back(ent(1, 0, 0, 0, "stop_to_off", ev(0, 0, 0, 0, 1, 0, 0)));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            arm = e.a; disarm = e.d; kill = e.k;
            cyc(e.gap);
            n_cmp++;
            if (obs() !== e.v) begin
                n_bad++;
                $display("[TB] FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v));
            end
        end
        disarm = 1'b0;
    endtask

    task automatic test_kill();
        ent_t e;
        int   w;
        logic [46:0] off_v;
        off_v = ev(0, 0, 0, 0, 1, 0, 0);
        frnt_tgt = 11'd300; bck_tgt = 11'd300; lft_tgt = 11'd300; rght_tgt = 11'd300;
        sb.push_back(ent(1, 1, 0, 0, "k_arming", ev(0, 0, 0, 0, 0, 0, 1)));
        sb.push_back(ent(3, 0, 0, 0, "k_arming_hold", ev(0, 0, 0, 0, 0, 0, 1)));
        sb.push_back(ent(1, 0, 0, 1, "kill_arming", off_v));
        sb.push_back(ent(2, 1, 0, 1, "kill_blocks_arm", off_v));
        sb.push_back(ent(1, 0, 0, 0, "kill_release", off_v));
        sb.push_back(ent(1, 1, 0, 0, "k_arm2", ev(0, 0, 0, 0, 0, 0, 1)));
        sb.push_back(ent(10, 0, 0, 0, "k_run2", ev(0, 0, 0, 0, 0, 1, 0)));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            arm = e.a; disarm = e.d; kill = e.k;
            cyc(e.gap);
            n_cmp++;
            if (obs() !== e.v) begin
                n_bad++;
                $display("[TB] FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v));
            end
        end
        w = 0;
        while (frnt_spd != 300 && w < 400) begin
            cyc(1);
            w++;
        end
        n_cmp++;
        if (obs() !== ev(300, 300, 300, 300, 0, 1, 0)) begin
            n_bad++;
            $display("[TB] FAIL reach_300: got %s, expected %s", fmt(obs()), fmt(ev(300, 300, 300, 300, 0, 1, 0)));
        end
        sb.push_back(ent(1, 0, 0, 1, "kill_run", off_v));
        sb.push_back(ent(1, 1, 0, 0, "k_arm3", ev(0, 0, 0, 0, 0, 0, 1)));
        sb.push_back(ent(10, 0, 0, 0, "k_run3", ev(0, 0, 0, 0, 0, 1, 0)));
        sb.push_back(ent(8, 0, 0, 0, "k_run3_ramp", ev(16, 16, 16, 16, 0, 1, 0)));
        sb.push_back(ent(1, 0, 1, 0, "k_stop3", ev(16, 16, 16, 16, 0, 0, 1)));
        sb.push_back(ent(2, 0, 0, 0, "k_stop3_hold", ev(16, 16, 16, 16, 0, 0, 1)));
        sb.push_back(ent(1, 0, 0, 1, "kill_stop", off_v));
        sb.push_back(ent(1, 1, 0, 0, "k_arm4", ev(0, 0, 0, 0, 0, 0, 1)));
        sb.push_back(ent(10, 0, 0, 0, "k_run4", ev(0, 0, 0, 0, 0, 1, 0)));
        sb.push_back(ent(1, 0, 1, 1, "kill_and_disarm", off_v));
        sb.push_back(ent(1, 0, 0, 0, "kill_and_disarm_after", off_v));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            arm = e.a; disarm = e.d; kill = e.k;
            cyc(e.gap);
            n_cmp++;
            if (obs() !== e.v) begin
                n_bad++;
                $display("[TB] FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v));
            end
        end
        arm = 1'b0; disarm = 1'b0; kill = 1'b0;
    endtask

    task automatic test_back_to_back();
        ent_t e;
        logic [46:0] off_v;
        off_v = ev(0, 0, 0, 0, 1, 0, 0);
        frnt_tgt = '0; bck_tgt = '0; lft_tgt = '0; rght_tgt = '0;
        sb.push_back(ent(1, 0, 1, 0, "disarm_in_off", off_v));
        sb.push_back(ent(1, 1, 0, 0, "b_arm", ev(0, 0, 0, 0, 0, 0, 1)));
        sb.push_back(ent(2, 0, 0, 0, "b_arming", ev(0, 0, 0, 0, 0, 0, 1)));
        sb.push_back(ent(1, 0, 1, 0, "disarm_arming", off_v));
        sb.push_back(ent(12, 0, 0, 0, "abort_stays_off", off_v));
        sb.push_back(ent(1, 1, 0, 0, "b_arm2", ev(0, 0, 0, 0, 0, 0, 1)));
        sb.push_back(ent(10, 0, 0, 0, "b_run2", ev(0, 0, 0, 0, 0, 1, 0)));
        sb.push_back(ent(1, 0, 1, 0, "stop_at_zero", ev(0, 0, 0, 0, 0, 0, 1)));
        sb.push_back(ent(1, 0, 0, 0, "stop_zero_off", off_v));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            arm = e.a; disarm = e.d; kill = e.k;
            cyc(e.gap);
            n_cmp++;
            if (obs() !== e.v) begin
                n_bad++;
                $display("[TB] FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v));
            end
        end
        frnt_tgt = 11'd40; bck_tgt = 11'd40; lft_tgt = 11'd40; rght_tgt = 11'd40;
        sb.push_back(ent(1, 1, 0, 0, "b_arm3", ev(0, 0, 0, 0, 0, 0, 1)));
        sb.push_back(ent(10, 0, 0, 0, "b_run3", ev(0, 0, 0, 0, 0, 1, 0)));
        sb.push_back(ent(3, 0, 0, 0, "b_run3_pre", ev(0, 0, 0, 0, 0, 1, 0)));
        sb.push_back(ent(1, 0, 1, 0, "disarm_on_tick", ev(8, 8, 8, 8, 0, 0, 1)));
        sb.push_back(ent(4, 0, 0, 0, "stop_after_tick", ev(0, 0, 0, 0, 0, 0, 1)));
        sb.push_back(ent(1, 0, 0, 0, "stop_after_tick_off", off_v));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            arm = e.a; disarm = e.d; kill = e.k;
            cyc(e.gap);
            n_cmp++;
            if (obs() !== e.v) begin
                n_bad++;
                $display("[TB] FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v));
            end
        end
        arm = 1'b0; disarm = 1'b0; kill = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arm();
        test_ramp_up();
        test_retarget();
        test_disarm();
        test_kill();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
